// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
// Holds the reset PC, the fetch FSM encoding and a word-alignment helper.
package fetch_ctrl_pkg;

  localparam logic [31:0] PC_START_ADDR = 32'h0000_0200;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux: trap beats redirect beats sequential +4.
// Flush targets are forced to word alignment.
module fetch_ctrl_next_pc_sel
  import fetch_ctrl_pkg::*;
(
  input  logic        flush_en,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pc_cur,
  output logic        flush,
  output logic [31:0] pc_next
);

  assign flush = flush_en & (trap_valid | redirect_valid);

  always_comb begin
    pc_next = pc_cur + PC_STEP;
    if (flush) begin
      pc_next = trap_valid ? align_word(trap_pc) : align_word(redirect_pc);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives program_counter, issues one-outstanding
// instruction-memory requests and delivers fetched words to IF/ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_e state_q, state_d;
  logic         drop_pending_q, drop_pending_d;
  logic [31:0]  hold_q, hold_d;
  logic         flush;
  logic         flush_en;

  assign flush_en  = (state_q != BOOT);
  assign imem_addr = pc_cur;
  assign if_pc     = pc_cur;

  fetch_ctrl_next_pc_sel u_next_pc_sel (
    .flush_en       (flush_en),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_cur         (pc_cur),
    .flush          (flush),
    .pc_next        (pc_next)
  );

  always_comb begin
    state_d        = state_q;
    drop_pending_d = drop_pending_q;
    hold_d         = hold_q;
    imem_req       = 1'b0;
    pc_en          = 1'b0;
    if_valid       = 1'b0;
    if_instr       = 32'd0;

    // The response owed to a flushed request is swallowed wherever it lands.
    if (drop_pending_q && imem_rvalid) begin
      drop_pending_d = 1'b0;
    end

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = !flush && !drop_pending_q;
        if (flush) begin
          pc_en   = 1'b1;
          state_d = REQ;
        end else if (imem_req && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_en   = 1'b1;
          state_d = REQ;
          if (!imem_rvalid) begin
            drop_pending_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if_valid = 1'b1;
          if_instr = imem_rdata;
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            pc_en   = 1'b1;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_en   = 1'b1;
          state_d = REQ;
        end else begin
          if_valid = 1'b1;
          if_instr = hold_q;
          if (!stall) begin
            pc_en   = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      drop_pending_q <= 1'b0;
      hold_q         <= 32'd0;
    end else begin
      state_q        <= state_d;
      drop_pending_q <= drop_pending_d;
      hold_q         <= hold_d;
    end
  end

endmodule
